ifetch_unit: RTL and testbench

Instruction-fetch stage directly downstream of the PC register. Takes the current PC, issues a single-outstanding request to instruction memory, and captures the returned word. Presents the word to decode on a valid/ready handshake and drives `pc_hold_o` back to the PC/NPC path, so the PC advances only when an instruction is consumed or a redirect occurs.

---
 rtl/ifetch_unit.sv | 121 ++++++++++++
 tb/tb_ifetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: single-outstanding imem request, captured word held on a
// valid/ready handshake to decode, and PC hold feedback to the PC/NPC path.
module ifetch_unit #(
  parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        redirect_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  output logic        if_fault_o,
  output logic        pc_hold_o,
  output logic [31:0] inst_cnt_o
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrop, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;
  logic        misaligned;

  assign misaligned = (pc_i[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    if_pc_d     = if_pc_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    imem_req_o  = 1'b0;
    imem_addr_o = 32'h0;
    if_valid_o  = 1'b0;
    pc_hold_o   = !(((state_q == StHold) && if_ready_i) || redirect_i);

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (misaligned) begin
          // Misaligned PC never reaches memory; report a fault in place of an instruction.
          if_pc_d = pc_i;
          inst_d  = RESET_INST;
          fault_d = 1'b1;
          state_d = StHold;
        end else begin
          imem_req_o  = 1'b1;
          imem_addr_o = pc_i;
          if (imem_gnt_i) begin
            pc_d    = pc_i;
            state_d = redirect_i ? StDrop : StWait;
          end
        end
      end
      StWait: begin
        if (imem_rvalid_i) begin
          if (redirect_i) begin
            state_d = StReq;
          end else begin
            inst_d  = imem_rdata_i;
            if_pc_d = pc_q;
            fault_d = 1'b0;
            state_d = StHold;
          end
        end else if (redirect_i) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (imem_rvalid_i) state_d = StReq;
      end
      StHold: begin
        if_valid_o = 1'b1;
        if (redirect_i) begin
          inst_d  = RESET_INST;
          fault_d = 1'b0;
          state_d = StReq;
        end else if (if_ready_i) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= 32'h0;
      inst_q  <= RESET_INST;
      if_pc_q <= 32'h0;
      fault_q <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      if_pc_q <= if_pc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign if_inst_o  = inst_q;
  assign if_pc_o    = if_pc_q;
  assign if_fault_o = fault_q;
  assign inst_cnt_o = cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: inputs driven and outputs checked mid-cycle (negedge + 1).
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        redirect_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
  logic        if_fault_o;
  logic        pc_hold_o;
  logic [31:0] inst_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .redirect_i   (redirect_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .if_valid_o   (if_valid_o),
    .if_ready_i   (if_ready_i),
    .if_inst_o    (if_inst_o),
    .if_pc_o      (if_pc_o),
    .if_fault_o   (if_fault_o),
    .pc_hold_o    (pc_hold_o),
    .inst_cnt_o   (inst_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next mid-cycle point, where new inputs are applied.
  task automatic next();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {31'h0, imem_req_o}, 32'h0);
    chk({tag, "_addr"},  imem_addr_o,         32'h0);
    chk({tag, "_valid"}, {31'h0, if_valid_o}, 32'h0);
    chk({tag, "_inst"},  if_inst_o,           32'h0000_0013);
    chk({tag, "_pc"},    if_pc_o,             32'h0);
    chk({tag, "_fault"}, {31'h0, if_fault_o}, 32'h0);
    chk({tag, "_hold"},  {31'h0, pc_hold_o},  32'h1);
    chk({tag, "_cnt"},   inst_cnt_o,          32'h0);
  endtask

  initial begin
    rst = 1'b1; pc_i = 32'h0; redirect_i = 1'b0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; if_ready_i = 1'b0;
    next(); next();

    // Test 1: zero-wait memory. Cycle 0 = IDLE after last reset edge.
    rst = 1'b0; settle();
    chk_reset_vals("t1_idle");
    next(); imem_gnt_i = 1'b1; if_ready_i = 1'b1; settle();          // cycle 1: REQ
    chk("t1_req",  {31'h0, imem_req_o}, 32'h1);
    chk("t1_addr", imem_addr_o, 32'h0);
    chk("t1_hold1", {31'h0, pc_hold_o}, 32'h1);
    next(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0010_0093; settle();
    chk("t1_wait_req",   {31'h0, imem_req_o}, 32'h0);              // cycle 2: WAIT
    chk("t1_wait_valid", {31'h0, if_valid_o}, 32'h0);
    chk("t1_hold2", {31'h0, pc_hold_o}, 32'h1);
    next(); imem_rvalid_i = 1'b0; settle();                          // cycle 3: HOLD
    chk("t1_valid", {31'h0, if_valid_o}, 32'h1);
    chk("t1_inst",  if_inst_o, 32'h0010_0093);
    chk("t1_pc",    if_pc_o, 32'h0);
    chk("t1_hold3", {31'h0, pc_hold_o}, 32'h0);
    next(); pc_i = 32'h4; if_ready_i = 1'b0; settle();               // cycle 4: REQ
    chk("t1_cnt",   inst_cnt_o, 32'h1);
    chk("t1_hold4", {31'h0, pc_hold_o}, 32'h1);
    chk("t1_valid_drop", {31'h0, if_valid_o}, 32'h0);

    // Test 2: grant stalled 3 cycles, rvalid 2 cycles after grant, decode stalled 4 cycles.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next();
      settle();
      chk("t2_stall_req",  {31'h0, imem_req_o}, 32'h1);
      chk("t2_stall_addr", imem_addr_o, 32'h4);
      chk("t2_stall_hold", {31'h0, pc_hold_o}, 32'h1);
    end
    next(); imem_gnt_i = 1'b1; settle();
    chk("t2_gnt_addr", imem_addr_o, 32'h4);
    next(); imem_gnt_i = 1'b0; settle();
    chk("t2_wait_hold", {31'h0, pc_hold_o}, 32'h1);
    next(); imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0020_0113; settle();
    next(); imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; settle();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next();
      settle();
      chk("t2_hold_valid", {31'h0, if_valid_o}, 32'h1);
      chk("t2_hold_inst",  if_inst_o, 32'h0020_0113);
      chk("t2_hold_pc",    if_pc_o, 32'h4);
      chk("t2_hold_hold",  {31'h0, pc_hold_o}, 32'h1);
      chk("t2_hold_cnt",   inst_cnt_o, 32'h1);
    end
    next(); if_ready_i = 1'b1; settle();
    chk("t2_consume_hold", {31'h0, pc_hold_o}, 32'h0);
    next(); if_ready_i = 1'b0; pc_i = 32'h8; settle();
    chk("t2_cnt", inst_cnt_o, 32'h2);

    // Test 3: redirect in WAIT without rvalid -> DROP, stale data discarded.
    imem_gnt_i = 1'b1;
    next(); imem_gnt_i = 1'b0; redirect_i = 1'b1; settle();          // WAIT
    chk("t3_redir_hold", {31'h0, pc_hold_o}, 32'h0);
    next(); redirect_i = 1'b0; pc_i = 32'h40; settle();              // DROP
    chk("t3_drop_req", {31'h0, imem_req_o}, 32'h0);
    next(); imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; settle();
    chk("t3_drop_req2", {31'h0, imem_req_o}, 32'h0);
    next(); imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1; settle();       // REQ
    chk("t3_req",   {31'h0, imem_req_o}, 32'h1);
    chk("t3_addr",  imem_addr_o, 32'h40);
    chk("t3_inst",  if_inst_o, 32'h0020_0113);
    chk("t3_valid", {31'h0, if_valid_o}, 32'h0);
    next(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0030_0193; settle();
    next(); imem_rvalid_i = 1'b0; settle();                          // HOLD
    chk("t3_hold_inst", if_inst_o, 32'h0030_0193);
    chk("t3_hold_pc",   if_pc_o, 32'h40);

    // Test 4: redirect in HOLD, then rvalid+redirect together in WAIT.
    redirect_i = 1'b1; settle();
    chk("t4_hold_redir", {31'h0, pc_hold_o}, 32'h0);
    next(); redirect_i = 1'b0; pc_i = 32'h80; imem_gnt_i = 1'b1; settle();   // REQ
    chk("t4_valid", {31'h0, if_valid_o}, 32'h0);
    chk("t4_flush_inst", if_inst_o, 32'h0000_0013);
    chk("t4_cnt", inst_cnt_o, 32'h2);
    next(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0040_0213;
    redirect_i = 1'b1; settle();                                     // WAIT
    chk("t4_both_hold", {31'h0, pc_hold_o}, 32'h0);
    next(); imem_rvalid_i = 1'b0; redirect_i = 1'b0; pc_i = 32'h84; settle();
    chk("t4_req",   {31'h0, imem_req_o}, 32'h1);
    chk("t4_addr",  imem_addr_o, 32'h84);
    chk("t4_inst",  if_inst_o, 32'h0000_0013);
    chk("t4_valid2", {31'h0, if_valid_o}, 32'h0);

    // Test 5: misaligned PC raises a fault without a memory request.
    pc_i = 32'h6; settle();
    chk("t5_req",  {31'h0, imem_req_o}, 32'h0);
    chk("t5_addr", imem_addr_o, 32'h0);
    next(); settle();                                                // HOLD
    chk("t5_valid", {31'h0, if_valid_o}, 32'h1);
    chk("t5_fault", {31'h0, if_fault_o}, 32'h1);
    chk("t5_inst",  if_inst_o, 32'h0000_0013);
    chk("t5_pc",    if_pc_o, 32'h6);
    if_ready_i = 1'b1;
    next(); if_ready_i = 1'b0; pc_i = 32'h100; imem_gnt_i = 1'b1; settle();  // REQ
    chk("t5_cnt", inst_cnt_o, 32'h3);

    // Test 6: reset in WAIT, late rvalid ignored, then counter wrap.
    next(); imem_gnt_i = 1'b0; rst = 1'b1; settle();                 // WAIT
    next(); rst = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678; settle();
    chk_reset_vals("t6_idle");
    next(); imem_rvalid_i = 1'b0; pc_i = 32'h200; settle();          // REQ
    chk("t6_valid", {31'h0, if_valid_o}, 32'h0);
    chk("t6_inst",  if_inst_o, 32'h0000_0013);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    imem_gnt_i = 1'b1;
    next(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0513; settle();
    next(); imem_rvalid_i = 1'b0; if_ready_i = 1'b1; settle();       // HOLD
    chk("t6_inst_hold", if_inst_o, 32'h0000_0513);
    chk("t6_cnt_pre", inst_cnt_o, 32'hFFFF_FFFF);
    next(); if_ready_i = 1'b0; settle();
    chk("t6_cnt_wrap", inst_cnt_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
